// File: rtl/gpio_axi_pkg.sv
// Shared constants, AXI payload types and FSM state enums for gpio_axi_banked.
package gpio_axi_pkg;

  localparam int unsigned AXI_DW      = 32;
  localparam int unsigned AXI_SW      = AXI_DW / 8;
  localparam int unsigned BANK_STRIDE = 32'h40;
  localparam int unsigned OFF_W       = $clog2(BANK_STRIDE);

  localparam logic [OFF_W-1:0] OFF_OUT     = OFF_W'('h00);
  localparam logic [OFF_W-1:0] OFF_SET     = OFF_W'('h04);
  localparam logic [OFF_W-1:0] OFF_CLR     = OFF_W'('h08);
  localparam logic [OFF_W-1:0] OFF_TGL     = OFF_W'('h0C);
  localparam logic [OFF_W-1:0] OFF_DIR     = OFF_W'('h10);
  localparam logic [OFF_W-1:0] OFF_IN      = OFF_W'('h14);
  localparam logic [OFF_W-1:0] OFF_RISE_EN = OFF_W'('h18);
  localparam logic [OFF_W-1:0] OFF_FALL_EN = OFF_W'('h1C);
  localparam logic [OFF_W-1:0] OFF_STATUS  = OFF_W'('h20);
  localparam logic [OFF_W-1:0] OFF_DB_EN   = OFF_W'('h24);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Captured W-channel beat
  typedef struct packed {
    logic [AXI_DW-1:0] data;
    logic [AXI_SW-1:0] strb;
  } axi_w_t;

  // Expand byte strobes into a bit mask
  function automatic logic [AXI_DW-1:0] strb_mask(input logic [AXI_SW-1:0] strb);
    logic [AXI_DW-1:0] m;
    for (int i = 0; i < int'(AXI_SW); i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_bank_in.sv
// Input path for one bank: 2-flop synchroniser, tick-sampled debounce,
// edge detection gated by rise/fall enables.
// Ports: clk/rst_n, pins (async pads), tick (debounce sample strobe),
//        db_en/rise_en/fall_en (per-pin controls), filt_c (filtered level),
//        evt_c (qualified edge events this cycle).
module gpio_bank_in #(
  parameter int unsigned BANK_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BANK_WIDTH-1:0] pins,
  input  logic                  tick,
  input  logic [BANK_WIDTH-1:0] db_en,
  input  logic [BANK_WIDTH-1:0] rise_en,
  input  logic [BANK_WIDTH-1:0] fall_en,
  output logic [BANK_WIDTH-1:0] filt_c,
  output logic [BANK_WIDTH-1:0] evt_c
);

  logic [BANK_WIDTH-1:0] sync1, sync2, sample, db_q, filt_q, db_upd;

  // A debounced bit may follow sync only on a tick where it matched the last sample
  assign db_upd = tick ? ~(sync2 ^ sample) : '0;

  // Synchroniser, debounce state and previous filtered level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sample <= '0;
      db_q   <= '0;
      filt_q <= '0;
    end else begin
      sync1  <= pins;
      sync2  <= sync1;
      if (tick) sample <= sync2;
      // Non-debounced bits keep db_q tracking sync so enabling debounce does not glitch
      db_q   <= (~db_en & sync2) | (db_en & ((db_upd & sync2) | (~db_upd & db_q)));
      filt_q <= filt_c;
    end
  end

  assign filt_c = (db_en & db_q) | (~db_en & sync2);
  assign evt_c  = (filt_c & ~filt_q & rise_en) | (~filt_c & filt_q & fall_en);

endmodule

// File: rtl/gpio_axi_banked.sv
// AXI4-Lite GPIO slave with NUM_BANKS banks of BANK_WIDTH pins.
// Ports: s_axi_* AXI4-Lite slave (aclk, async active-low aresetn),
//        gpio_i pad inputs, gpio_o/gpio_oe pad drive, intr level interrupt.
module gpio_axi_banked
  import gpio_axi_pkg::*;
#(
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned BANK_WIDTH     = 32,
  parameter int unsigned DB_TICK_CYCLES = 1000,
  parameter int unsigned ADDR_WIDTH     = 12
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [31:0]                      s_axi_wdata,
  input  logic [3:0]                       s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [31:0]                      s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  input  logic [NUM_BANKS*BANK_WIDTH-1:0]  gpio_i,
  output logic [NUM_BANKS*BANK_WIDTH-1:0]  gpio_o,
  output logic [NUM_BANKS*BANK_WIDTH-1:0]  gpio_oe,
  output logic                             intr
);

  localparam int unsigned BIDX_W = ADDR_WIDTH - OFF_W;
  localparam int unsigned TICK_W = $clog2(DB_TICK_CYCLES);

  typedef logic [BANK_WIDTH-1:0] bank_t;

  bank_t out_r [NUM_BANKS];
  bank_t dir_r [NUM_BANKS];
  bank_t rise_r[NUM_BANKS];
  bank_t fall_r[NUM_BANKS];
  bank_t stat_r[NUM_BANKS];
  bank_t db_r  [NUM_BANKS];
  bank_t filt  [NUM_BANKS];
  bank_t evt   [NUM_BANKS];

  w_state_t               w_state, w_state_d;
  r_state_t               r_state, r_state_d;
  logic                   aw_done, aw_done_d, w_done, w_done_d;
  logic                   awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic [1:0]             bresp_d, rresp_d;
  logic [31:0]            rdata_d, rd_val;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  axi_w_t                 wpay_q, wpay_d;
  logic                   aw_fire, w_fire, ar_fire, wr_en;
  logic [BIDX_W-1:0]      wr_bank, rd_bank;
  logic [OFF_W-1:0]       wr_off, rd_off;
  bank_t                  wr_m, wr_d;
  logic                   any_status;
  logic [TICK_W-1:0]      tick_cnt;
  logic                   tick_c;

  // Unaligned, unmapped, out-of-range bank, or a write to the read-only IN register
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a, input logic is_wr);
    logic [OFF_W-1:0]  off;
    logic [BIDX_W-1:0] bank;
    off  = a[OFF_W-1:0];
    bank = a[ADDR_WIDTH-1:OFF_W];
    return (a[1:0] != 2'b00) || (off > OFF_DB_EN) || (32'(bank) >= NUM_BANKS) ||
           (is_wr && (off == OFF_IN));
  endfunction

  // Shared debounce prescaler
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) tick_cnt <= '0;
    else                tick_cnt <= tick_c ? '0 : tick_cnt + 1'b1;
  end
  assign tick_c = (tick_cnt == TICK_W'(DB_TICK_CYCLES - 1));

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    gpio_bank_in #(.BANK_WIDTH(BANK_WIDTH)) u_in (
      .clk     (s_axi_aclk),
      .rst_n   (s_axi_aresetn),
      .pins    (gpio_i[b*BANK_WIDTH +: BANK_WIDTH]),
      .tick    (tick_c),
      .db_en   (db_r[b]),
      .rise_en (rise_r[b]),
      .fall_en (fall_r[b]),
      .filt_c  (filt[b]),
      .evt_c   (evt[b])
    );
    assign gpio_o [b*BANK_WIDTH +: BANK_WIDTH] = out_r[b];
    assign gpio_oe[b*BANK_WIDTH +: BANK_WIDTH] = dir_r[b];
  end

  // Write and read FSM state registers with their registered outputs
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state       <= W_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      awaddr_q      <= '0;
      wpay_q        <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      w_state       <= w_state_d;
      aw_done       <= aw_done_d;
      w_done        <= w_done_d;
      awaddr_q      <= awaddr_d;
      wpay_q        <= wpay_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
      r_state       <= r_state_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
    end
  end

  // Write FSM: capture AW and W independently, commit once both are held
  always_comb begin
    w_state_d = w_state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    awaddr_d  = awaddr_q;
    wpay_d    = wpay_q;
    awready_d = s_axi_awready;
    wready_d  = s_axi_wready;
    bvalid_d  = s_axi_bvalid;
    bresp_d   = s_axi_bresp;
    wr_en     = 1'b0;
    aw_fire   = s_axi_awvalid & s_axi_awready;
    w_fire    = s_axi_wvalid & s_axi_wready;
    unique case (w_state)
      W_IDLE: begin
        if (aw_fire) begin
          awaddr_d  = s_axi_awaddr;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wpay_d   = '{data: s_axi_wdata, strb: s_axi_wstrb};
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          wr_en     = ~addr_err(awaddr_d, 1'b1);
          bresp_d   = addr_err(awaddr_d, 1'b1) ? RESP_SLVERR : RESP_OKAY;
          bvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          awready_d = ~aw_done_d;
          wready_d  = ~w_done_d;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign wr_bank = awaddr_d[ADDR_WIDTH-1:OFF_W];
  assign wr_off  = awaddr_d[OFF_W-1:0];
  assign wr_m    = BANK_WIDTH'(strb_mask(wpay_d.strb));
  assign wr_d    = BANK_WIDTH'(wpay_d.data) & wr_m;

  // Register file; hardware event set takes priority over a same-cycle W1C
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        out_r[b]  <= '0;
        dir_r[b]  <= '0;
        rise_r[b] <= '0;
        fall_r[b] <= '0;
        stat_r[b] <= '0;
        db_r[b]   <= '0;
      end
      intr <= 1'b0;
    end else begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        if (wr_en && (wr_bank == BIDX_W'(b))) begin
          unique case (wr_off)
            OFF_OUT:     out_r[b]  <= (out_r[b] & ~wr_m) | wr_d;
            OFF_SET:     out_r[b]  <= out_r[b] | wr_d;
            OFF_CLR:     out_r[b]  <= out_r[b] & ~wr_d;
            OFF_TGL:     out_r[b]  <= out_r[b] ^ wr_d;
            OFF_DIR:     dir_r[b]  <= (dir_r[b] & ~wr_m) | wr_d;
            OFF_RISE_EN: rise_r[b] <= (rise_r[b] & ~wr_m) | wr_d;
            OFF_FALL_EN: fall_r[b] <= (fall_r[b] & ~wr_m) | wr_d;
            OFF_DB_EN:   db_r[b]   <= (db_r[b] & ~wr_m) | wr_d;
            default: ;
          endcase
        end
        stat_r[b] <= (stat_r[b] &
                      ~((wr_en && (wr_bank == BIDX_W'(b)) && (wr_off == OFF_STATUS)) ? wr_d : '0))
                     | evt[b];
      end
      intr <= any_status;
    end
  end

  always_comb begin
    any_status = 1'b0;
    for (int b = 0; b < int'(NUM_BANKS); b++) any_status = any_status | (|stat_r[b]);
  end

  assign rd_bank = s_axi_araddr[ADDR_WIDTH-1:OFF_W];
  assign rd_off  = s_axi_araddr[OFF_W-1:0];

  // Read mux; SET/CLR/TGL and unmapped offsets read as zero
  always_comb begin
    rd_val = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (rd_bank == BIDX_W'(b)) begin
        unique case (rd_off)
          OFF_OUT:     rd_val = 32'(out_r[b]);
          OFF_DIR:     rd_val = 32'(dir_r[b]);
          OFF_IN:      rd_val = 32'(filt[b]);
          OFF_RISE_EN: rd_val = 32'(rise_r[b]);
          OFF_FALL_EN: rd_val = 32'(fall_r[b]);
          OFF_STATUS:  rd_val = 32'(stat_r[b]);
          OFF_DB_EN:   rd_val = 32'(db_r[b]);
          default:     rd_val = '0;
        endcase
      end
    end
  end

  // Read FSM: one-cycle AR-to-R latency, single outstanding read
  always_comb begin
    r_state_d = r_state;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rdata_d   = s_axi_rdata;
    rresp_d   = s_axi_rresp;
    ar_fire   = s_axi_arvalid & s_axi_arready;
    unique case (r_state)
      R_IDLE: begin
        if (ar_fire) begin
          rdata_d   = addr_err(s_axi_araddr, 1'b0) ? '0 : rd_val;
          rresp_d   = addr_err(s_axi_araddr, 1'b0) ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

endmodule
